// File: rtl/clock_div_multi.sv
`default_nettype none
// ============================================================================
//  Module   : clock_div_multi
//  Purpose  : Multi-channel synchronous clock divider. Each channel runs a
//             down-counter on the single system clock. It produces a
//             one-cycle tick enable and a registered near-50 % divided clock.
//             The divide ratio is programmable at run time. A new ratio is
//             captured into a pending slot and takes effect only at the
//             channel's terminal count, so the output never glitches.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH       : counter / divide-ratio width (ratios 0 .. 2^WIDTH-1)
//    CHANNELS    : number of divider channels (>= 1)
//    DEFAULT_DIV : ratio of every channel after reset
//  Ports
//    clock_i          in   1         system clock, rising edge
//    reset_ni         in   1         asynchronous reset, active low
//    enable_i         in   1         global advance enable
//    load_i           in   CHANNELS  per-channel strobe capturing div_value_i
//    div_value_i      in   WIDTH     new ratio, shared by all channels
//    load_pending_o   out  CHANNELS  captured ratio waiting for terminal count
//    tick_o           out  CHANNELS  one-cycle pulse, once per D advances
//    div_clock_o      out  CHANNELS  registered divided clock
//  Build option
//    CLOCK_DIV_CASCADE_EN : when defined, channel i>0 advances only on edges
//                           where the registered tick of channel i-1 is high.
//                           Effective ratios then multiply down the chain.
// ============================================================================
module clock_div_multi #(
    parameter int WIDTH       = 17,
    parameter int CHANNELS    = 2,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                enable_i,
    input  logic [CHANNELS-1:0] load_i,
    input  logic [WIDTH-1:0]    div_value_i,
    output logic [CHANNELS-1:0] load_pending_o,
    output logic [CHANNELS-1:0] tick_o,
    output logic [CHANNELS-1:0] div_clock_o
);

    localparam logic [WIDTH-1:0] C_DIV_RST = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    // Registered ticks of all channels. In cascade builds they feed the
    // advance condition of the next stage.
    logic [CHANNELS-1:0] tick_vec;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch

        logic adv;

`ifdef CLOCK_DIV_CASCADE_EN
        if (gi == 0) begin : g_head
            assign adv = enable_i;
        end else begin : g_tail
            // The registered tick of the previous stage gates this stage,
            // which adds one clock of latency per stage.
            assign adv = enable_i & tick_vec[gi-1];
        end
`else
        assign adv = enable_i;
`endif

        logic [WIDTH-1:0] cnt_q,  cnt_d;
        logic [WIDTH-1:0] div_q,  div_d;
        logic [WIDTH-1:0] pend_q, pend_d;
        logic             pending_q, pending_d;
        logic             tick_q, tick_d;
        logic             dclk_q, dclk_d;
        logic             apply;
        logic [WIDTH-1:0] ratio;
        logic [WIDTH-1:0] half;

        always_comb begin
            cnt_d     = cnt_q;
            div_d     = div_q;
            pend_d    = pend_q;
            pending_d = pending_q;
            tick_d    = 1'b0;
            dclk_d    = dclk_q;

            // A pending ratio is applied only at a cycle boundary. A stopped
            // channel (D=0) is always at a boundary. A stopped channel always
            // holds cnt at 0.
            apply = adv & pending_q & ((cnt_q == '0) | (div_q == '0));
            ratio = apply ? pend_q : div_q;
            half  = ratio >> 1;

            if (apply) begin
                div_d     = pend_q;
                pending_d = 1'b0;
            end

            if (adv) begin
                if (ratio == '0) begin
                    cnt_d  = '0;
                    dclk_d = 1'b0;
                end else begin
                    if (cnt_q == '0) begin
                        cnt_d  = ratio - C_ONE;
                        tick_d = 1'b1;
                    end else begin
                        cnt_d  = cnt_q - C_ONE;
                    end
                    // The high phase is the upper part of the count range.
                    // This gives ceil(D/2) high cycles per period.
                    dclk_d = (cnt_d >= half);
                end
            end

            // Capture goes to the pending slot only. A load that coincides
            // with a terminal count therefore waits for the next one.
            if (load_i[gi]) begin
                pend_d    = div_value_i;
                pending_d = 1'b1;
            end
        end

        always_ff @(posedge clock_i or negedge reset_ni) begin
            if (!reset_ni) begin
                cnt_q     <= '0;
                div_q     <= C_DIV_RST;
                pend_q    <= '0;
                pending_q <= 1'b0;
                tick_q    <= 1'b0;
                dclk_q    <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                div_q     <= div_d;
                pend_q    <= pend_d;
                pending_q <= pending_d;
                tick_q    <= tick_d;
                dclk_q    <= dclk_d;
            end
        end

        assign tick_vec[gi]       = tick_q;
        assign load_pending_o[gi] = pending_q;
        assign div_clock_o[gi]    = dclk_q;
    end

    assign tick_o = tick_vec;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clock_div_multi
//  Purpose  : Self-checking bench for clock_div_multi. A phase-based
//             reference model tracks each channel: the advance index within
//             the current period and the active ratio. Each output is
//             compared after every clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clock_div_multi;

    localparam int W   = 17;
    localparam int CH  = 2;
    localparam int DEF = 2;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [CH-1:0] load;
    logic [W-1:0]  div_value;
    logic [CH-1:0] load_pending;
    logic [CH-1:0] tick;
    logic [CH-1:0] div_clock;

    int vectors;
    int miscompares;

    // Reference model state
    int            m_div  [CH];
    int            m_k    [CH];   // advance index inside the current period
    int            m_pend [CH];
    logic [CH-1:0] m_pending;
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_dc;

    clock_div_multi #(
        .WIDTH      (W),
        .CHANNELS   (CH),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clock_i       (clk),
        .reset_ni      (rst_n),
        .enable_i      (enable),
        .load_i        (load),
        .div_value_i   (div_value),
        .load_pending_o(load_pending),
        .tick_o        (tick),
        .div_clock_o   (div_clock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int ch, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s ch%0d observed=%0b expected=%0b", tag, ch, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < CH; i++) begin
            chk("tick", i, tick[i], m_tick[i]);
            chk("div_clock", i, div_clock[i], m_dc[i]);
            chk("load_pending", i, load_pending[i], m_pending[i]);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_div[i]  = DEF;
            m_k[i]    = DEF - 1;   // the first advance starts a fresh period
            m_pend[i] = 0;
        end
        m_pending = '0;
        m_tick    = '0;
        m_dc      = '0;
    endtask

    task automatic model_edge(input logic en, input logic [CH-1:0] ld, input int dv);
        logic [CH-1:0] prev;
        logic          adv;
        bit            boundary;
        prev = m_tick;
        for (int i = 0; i < CH; i++) begin
            adv = en;
`ifdef CLOCK_DIV_CASCADE_EN
            if (i > 0) adv = en && prev[i-1];
`endif
            if (adv) begin
                boundary = (m_div[i] == 0) || (m_k[i] >= m_div[i] - 1);
                if (boundary && m_pending[i]) begin
                    m_div[i]     = m_pend[i];
                    m_pending[i] = 1'b0;
                end
                if (m_div[i] == 0) begin
                    m_tick[i] = 1'b0;
                    m_dc[i]   = 1'b0;
                    m_k[i]    = 0;
                end else begin
                    if (boundary) begin
                        m_k[i]    = 0;
                        m_tick[i] = 1'b1;
                    end else begin
                        m_k[i]    = m_k[i] + 1;
                        m_tick[i] = 1'b0;
                    end
                    // The first ceil(D/2) advances of each period are high.
                    m_dc[i] = (m_k[i] < (m_div[i] + 1) / 2);
                end
            end else begin
                m_tick[i] = 1'b0;
            end
            if (ld[i]) begin
                m_pend[i]    = dv;
                m_pending[i] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic en, input logic [CH-1:0] ld, input logic [W-1:0] dv);
        enable    = en;
        load      = ld;
        div_value = dv;
        @(posedge clk);
        model_edge(en, ld, int'(dv));
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step(1'b1, '0, '0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        enable      = 1'b0;
        load        = '0;
        div_value   = '0;
        rst_n       = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_all();

        // Default ratio 2 on both channels
        run(6);

        // Ratio 4 on channel 0; channel 1 stays at 2
        step(1'b1, 2'b01, W'(4));
        run(12);

        // Ratio 5 loaded mid-cycle on channel 1
        step(1'b1, 2'b10, W'(5));
        run(14);

        // Stop channel 0, then restart it with ratio 3
        step(1'b1, 2'b01, W'(0));
        run(8);
        step(1'b1, 2'b01, W'(3));
        run(9);

        // Enable low for 7 cycles with a load inside the window
        for (int c = 0; c < 7; c++)
            step(1'b0, (c == 3) ? 2'b10 : 2'b00, W'(2));
        run(8);

        // Last load wins: max ratio overwritten before it can be applied
        step(1'b1, 2'b01, W'(4));
        run(5);
        step(1'b1, 2'b01, {W{1'b1}});
        step(1'b1, 2'b01, W'(1));
        run(10);

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 11) == 0) ? CH'($urandom_range(1, (1 << CH) - 1)) : '0,
                 W'($urandom_range(0, 9)));
        end

        // Asynchronous reset mid-count
        step(1'b1, 2'b11, W'(2));
        run(5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Ratios 3 and 4 (multiply down the chain in cascade builds)
        step(1'b1, 2'b01, W'(3));
        step(1'b1, 2'b10, W'(4));
        run(40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/clock_div_multi.md
# clock_div_multi

Parametrised, fully synchronous multi-channel clock divider. It replaces ripple-flop division with per-channel down-counters clocked by the single system clock. Each channel has a run-time programmable divide ratio and produces a one-cycle `tick` enable plus a registered near-50 % `div_clock`. Ratio changes apply glitch-free at the channel's terminal count. It sits between the board clock and the slow-rate consumers (display scan, debouncers, ALU step logic).

## Interface
- `WIDTH`, 17: counter and divide-value width; ratios 0..2^WIDTH-1.
- `CHANNELS`, 2: number of independent divider channels (≥1).
- `DEFAULT_DIV`, 2: divide value of every channel after reset.

- `clock`  input  1  system clock; all logic on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  global advance enable.
- `load`  input  CHANNELS  per-channel one-cycle strobe; captures `div_value`.
- `div_value`  input  WIDTH  new divide ratio D, shared by all channels.
- `load_pending`  output  CHANNELS  a captured ratio is waiting for terminal count.
- `tick`  output  CHANNELS  one-cycle pulse, once per D advances.
- `div_clock`  output  CHANNELS  registered divided clock.

## Operation
- Per-channel state:
  - `cnt`: WIDTH bits, counts down.
  - `div`: WIDTH bits, active ratio D.
  - `pend`: WIDTH bits, captured ratio.
  - `load_pending`: flag.
- Reset (`reset`=0, asynchronous) sets `cnt`=0, `div`=DEFAULT_DIV, `pend`=0, `tick`=0, `div_clock`=0 and `load_pending`=0.
- A channel advances on an edge when `enable`=1 (see Configuration for cascade).
- Advance with D≥1:
  - `cnt`==0: reload `cnt`←D-1 and set `tick`←1.
  - Otherwise: `cnt`←`cnt`-1 and set `tick`←0.
- `div_clock` ← (next `cnt` ≥ floor(D/2)).
  - Even D gives exactly 50 %.
  - Odd D is high for ceil(D/2) cycles.
  - D=1 gives `tick` every advance and `div_clock` constantly 1.
- D=0 stops the channel: `cnt` holds 0, `tick`=0, `div_clock`=0.
- No-advance edge: `tick`←0; `cnt` and `div_clock` hold.
- Load handling:
  - `load[i]`=1 captures `div_value` into `pend` and sets `load_pending`, regardless of `enable`.
  - A second load before it is applied overwrites `pend`; the last one wins.
- Applying a pending ratio happens on an advancing edge where `cnt`==0, or any advancing edge if the current D=0.
  - `div`←`pend`, `load_pending`←0.
  - The reload uses the new D: `cnt`←`pend`-1 and `tick`←1, or a stopped channel if `pend`=0.
  - The cycle in progress always completes at the old ratio.
- A load in the same cycle as a terminal count is not applied at that terminal count; it becomes pending for the next one.

## Timing
- `tick` and `div_clock` are registered, with no combinational path from inputs.
- First `tick` comes on the first advancing edge after reset release (`cnt` starts at 0).
- Tick period is exactly D advances.
- `load_pending` rises one edge after `load` and falls on the edge that applies the ratio.
- Deasserting `enable` freezes phase; reasserting resumes from the same `cnt`.
- Reset mid-count is asynchronous; all state returns to reset values immediately.

## Configuration
- `CLOCK_DIV_CASCADE_EN` defined:
  - Channel i>0 advances only on edges where `enable`=1 and `tick[i-1]`=1 (registered value).
  - Effective ratios multiply down the chain.
  - Each stage adds one clock of latency to its `tick` relative to its predecessor's.
  - Channel 0 is unchanged.
- `CLOCK_DIV_CASCADE_EN` undefined: every channel advances on every `enable`=1 edge, fully independent.

## Test plan
- **Default ratio:** reset, `enable`=1, D=2 default → each channel `tick`=1 on edges 1,3,5…; `div_clock` 1,0,1,0.
- **Load D=4 on ch0:** load then wait for the reload → ch0 `tick` every 4 edges; `div_clock` pattern 1,1,0,0; ch1 unaffected.
- **Load D=5 mid-cycle:** → `load_pending`=1 until the old cycle finishes; next reload period 5 with `div_clock` high 3 cycles, low 2; no short pulse.
- **Stop and restart:**
  - Load D=0 → `tick` and `div_clock` stay 0.
  - Load D=3 → `tick` on the next advancing edge, then every 3.
- **Enable low and mid-count reset:**
  - `enable` low for 7 cycles → outputs hold, `tick`=0; a load during that window sets `load_pending`.
  - Reset asserted mid-count → all outputs 0 immediately.
- **Cascade (`CLOCK_DIV_CASCADE_EN`), ch0 D=3, ch1 D=4:** ch1 `tick` once per 12 clocks, one cycle after a ch0 tick.
